seq_div_106: RTL and testbench

SEQ_DIV_106 -- requirements
Module: seq_div_106

---
 rtl/div_pkg.sv | 14 +
 rtl/div_step.sv | 32 +++
 rtl/seq_div_106.sv | 109 ++++++++++
 tb/tb_seq_div_106.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and FSM state type for the sequential restoring divider.
package div_pkg;

  localparam int DEF_M = 106;
  localparam int DEF_N = 53;
  localparam int CNT_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 iteration: shift in a dividend bit, trial-subtract, select.
module div_step
  import div_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N-1:0] rem,
  input  logic         din,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] rem_next,
  output logic         qbit
);

  logic [N:0]   partial_s;
  logic [N-1:0] trial_s;
  logic         ge_s;

  // trial subtract; the low N bits of the difference are exact whenever partial >= divisor
  always_comb begin
    partial_s = {rem, din};
    ge_s      = (partial_s >= {1'b0, divisor});
    trial_s   = partial_s[N-1:0] - divisor;
    if (ge_s) begin
      rem_next = trial_s;
      qbit     = 1'b1;
    end else begin
      rem_next = partial_s[N-1:0];
      qbit     = 1'b0;
    end
  end

endmodule

// File: rtl/seq_div_106.sv
// Sequential unsigned divider: one quotient bit per cycle, MSB first, IDLE/CALC/DONE control.
module seq_div_106
  import div_pkg::*;
#(
  parameter int M = DEF_M,
  parameter int N = DEF_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  output logic [M-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         dz
);

  state_e           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [M-1:0]     dq_r;
  logic [N-1:0]     rem_r;
  logic [N-1:0]     dvs_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [M-1:0]     quot_r;
  logic [N-1:0]     rem_out_r;
  logic             dz_r;
  logic [N-1:0]     rem_next_s;
  logic             qbit_s;

  div_step #(.N(N)) u_step (
    .rem      (rem_r),
    .din      (dq_r[M-1]),
    .divisor  (dvs_r),
    .rem_next (rem_next_s),
    .qbit     (qbit_s)
  );

  // control FSM plus datapath; dq_r shifts the dividend out and the quotient in
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      dq_r        <= {M{1'b0}};
      rem_r       <= {N{1'b0}};
      dvs_r       <= {N{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      quot_r      <= {M{1'b0}};
      rem_out_r   <= {N{1'b0}};
      dz_r        <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (in_valid && in_ready_r) begin
            dq_r       <= dividend;
            dvs_r      <= divisor;
            rem_r      <= {N{1'b0}};
            cnt_r      <= CNT_W'(M - 1);
            in_ready_r <= 1'b0;
            if (divisor == {N{1'b0}}) begin
              state_r     <= ST_DONE;
              out_valid_r <= 1'b1;
              dz_r        <= 1'b1;
              quot_r      <= {M{1'b1}};
              rem_out_r   <= {N{1'b0}};
            end else begin
              state_r <= ST_CALC;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CALC: begin
          dq_r  <= {dq_r[M-2:0], qbit_s};
          rem_r <= rem_next_s;
          // final iteration publishes results so out_valid lines up with DONE
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r     <= ST_DONE;
            out_valid_r <= 1'b1;
            dz_r        <= 1'b0;
            quot_r      <= {dq_r[M-2:0], qbit_s};
            rem_out_r   <= rem_next_s;
          end else begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          state_r    <= ST_IDLE;
          in_ready_r <= 1'b1;
        end
        default: begin
          state_r    <= ST_IDLE;
          in_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign quotient  = quot_r;
  assign remainder = rem_out_r;
  assign dz        = dz_r;

endmodule

// File: tb/tb_seq_div_106.sv
// Scoreboard bench for seq_div_106: stimulus pushes expected results, a negedge monitor checks them.
module tb_seq_div_106;
  import div_pkg::*;

  localparam int M = DEF_M;
  localparam int N = DEF_N;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] dividend;
  logic [N-1:0] divisor;
  logic         out_valid;
  logic [M-1:0] quotient;
  logic [N-1:0] remainder;
  logic         dz;

  typedef struct {
    logic [M-1:0] q;
    logic [N-1:0] r;
    logic         dz;
    int           cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  seq_div_106 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .quotient  (quotient),
    .remainder (remainder),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // monitor: every out_valid pulse must match the oldest scoreboard entry
  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got out_valid=1 expected none pending (cyc %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        check("quotient", 128'(quotient), 128'(e.q));
        check("remainder", 128'(remainder), 128'(e.r));
        check("dz", 128'(dz), 128'(e.dz));
        check("latency_cycle", 128'(cyc), 128'(e.cyc));
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (in_ready !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: got in_ready=%b expected 1", in_ready);
    end
  endtask

  task automatic issue(input logic [M-1:0] a, input logic [N-1:0] b, input bit push,
                       input logic [M-1:0] eq, input logic [N-1:0] er, input logic edz,
                       input int lat, output int e_cyc);
    exp_t e;
    @(negedge clk);
    wait_ready();
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    e_cyc    = cyc;
    in_valid = 1'b0;
    if (push) begin
      e.q   = eq;
      e.r   = er;
      e.dz  = edz;
      e.cyc = e_cyc + lat;
      sb_q.push_back(e);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sb_q.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    logic [M-1:0] ones_m;
    logic [N-1:0] ones_n;
    logic [M-1:0] q_big;
    int           e0;
    int           e1;
    int           e2;
    int           t;
    exp_t         ex;

    ones_m    = {M{1'b1}};
    ones_n    = {N{1'b1}};
    q_big     = {M{1'b0}};
    q_big[53] = 1'b1;
    q_big[0]  = 1'b1;

    rst      = 1'b1;
    in_valid = 1'b0;
    dividend = {M{1'b0}};
    divisor  = {N{1'b0}};
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_in_ready", 128'(in_ready), 128'(1'b1));
    check("reset_out_valid", 128'(out_valid), 128'(1'b0));
    check("reset_quotient", 128'(quotient), 128'(0));
    check("reset_remainder", 128'(remainder), 128'(0));
    check("reset_dz", 128'(dz), 128'(1'b0));

    issue(106'd100, 53'd7, 1'b1, 106'd14, 53'd2, 1'b0, M, e0);
    drain();

    issue(ones_m, ones_n, 1'b1, q_big, 53'd0, 1'b0, M, e0);
    drain();

    issue(106'd12345, 53'd0, 1'b1, ones_m, 53'd0, 1'b1, 0, e0);
    drain();
    repeat (3) @(negedge clk);
    check("dz_hold_quotient", 128'(quotient), 128'(ones_m));
    check("dz_hold_flag", 128'(dz), 128'(1'b1));

    issue(106'd5, 53'd9, 1'b1, 106'd0, 53'd5, 1'b0, M, e0);
    drain();

    // abort a calculation with reset while in_valid toggles underneath
    issue(106'd100, 53'd7, 1'b0, 106'd0, 53'd0, 1'b0, M, e0);
    dividend = 106'd9;
    divisor  = 53'd3;
    while (cyc < e0 + 49) begin
      @(negedge clk);
      in_valid = ~in_valid;
      if (cyc == e0 + 10) check("calc_in_ready", 128'(in_ready), 128'(1'b0));
    end
    in_valid = 1'b1;
    rst      = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    check("abort_in_ready", 128'(in_ready), 128'(1'b1));
    check("abort_out_valid", 128'(out_valid), 128'(1'b0));
    check("abort_quotient", 128'(quotient), 128'(0));
    check("abort_remainder", 128'(remainder), 128'(0));
    check("abort_dz", 128'(dz), 128'(1'b0));
    repeat (150) @(negedge clk);

    // back-to-back with in_valid held high
    @(negedge clk);
    wait_ready();
    dividend = 106'd100;
    divisor  = 53'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    e1     = cyc;
    ex.q   = 106'd14;
    ex.r   = 53'd2;
    ex.dz  = 1'b0;
    ex.cyc = e1 + M;
    sb_q.push_back(ex);
    @(negedge clk);
    dividend = 106'd1000;
    divisor  = 53'd10;
    t = 0;
    while (in_ready !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    e2       = cyc;
    in_valid = 1'b0;
    ex.q     = 106'd100;
    ex.r     = 53'd0;
    ex.dz    = 1'b0;
    ex.cyc   = e2 + M;
    sb_q.push_back(ex);
    check("held_accept_edge", 128'(e2), 128'(e1 + M + 2));
    drain();
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
